// File: rtl/tt_sel_seq_pkg.sv
// Shared state encoding and default sizes for the tt_sel_seq select sequencer.
package tt_sel_seq_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int PW_W_DEF   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIS    = 3'd1,
        RST_LO = 3'd2,
        RST_HI = 3'd3,
        INC_HI = 3'd4,
        INC_LO = 3'd5,
        ENA    = 3'd6
    } state_t;

endpackage

// File: rtl/tt_sel_seq_tmr.sv
// Loadable saturating down-counter; expire is high while the count sits at zero.
module tt_sel_seq_tmr
    import tt_sel_seq_pkg::*;
#(
    parameter int W = PW_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] value_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; the count parks at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sel_seq.sv
// Select-pin sequencer for tt_ctrl: turns an address request into the reset / increment / enable train.
// Optional macro TT_SEL_SEQ_FAST_EN: count up from the current address instead of resetting when possible.
module tt_sel_seq
    import tt_sel_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PW_W   = PW_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PW_W-1:0]   cfg_pw,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    state_t            state_q, state_d;
    logic [PW_W-1:0]   wm1_q, wm1_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] n_load;
    logic              skip_q, skip_d, skip_load;
    logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic              sel_rst_n_q, sel_rst_n_d, inc_q, inc_d, ena_q, ena_d;
    logic              accept, ph_load, ph_expire, inc_dec, inc_zero;

    // Request capture: phase width, target and increment count are frozen at accept.
    always_comb begin
        accept    = req_valid && ready_q;
        n_load    = req_addr;
        skip_load = 1'b0;
`ifdef TT_SEL_SEQ_FAST_EN
        if (req_addr >= cur_addr_q) begin
            n_load    = req_addr - cur_addr_q;
            skip_load = 1'b1;
        end
`endif
        wm1_d    = wm1_q;
        target_d = target_q;
        skip_d   = skip_q;
        if (accept) begin
            wm1_d    = (cfg_pw == '0) ? '0 : cfg_pw - PW_W'(1);
            target_d = req_addr;
            skip_d   = skip_load;
        end
    end

    tt_sel_seq_tmr #(.W(PW_W)) u_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ph_load),
        .dec_i    (1'b1),
        .value_i  (wm1_d),
        .expire_o (ph_expire)
    );

    tt_sel_seq_tmr #(.W(ADDR_W)) u_inc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept),
        .dec_i    (inc_dec),
        .value_i  (n_load),
        .expire_o (inc_zero)
    );

    // Every state change reloads the phase timer, so each timed phase lasts W cycles.
    always_comb begin
        state_d = state_q;
        inc_dec = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = DIS;
            DIS:     if (ph_expire) state_d = skip_q ? (inc_zero ? ENA : INC_HI) : RST_LO;
            RST_LO:  if (ph_expire) state_d = RST_HI;
            RST_HI:  if (ph_expire) state_d = inc_zero ? ENA : INC_HI;
            INC_HI: begin
                if (ph_expire) begin
                    state_d = INC_LO;
                    inc_dec = 1'b1;
                end
            end
            INC_LO:  if (ph_expire) state_d = inc_zero ? ENA : INC_HI;
            ENA:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ph_load = (state_d != state_q);
    end

    // Outputs decode the next state so every pin comes straight from a flop.
    always_comb begin
        ready_d     = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        sel_rst_n_d = (state_d != RST_LO);
        inc_d       = (state_d == INC_HI);
        done_d      = (state_d == ENA);
        ena_d       = 1'b0;
        cur_addr_d  = cur_addr_q;
        if (state_d == ENA) begin
            ena_d      = 1'b1;
            cur_addr_d = target_q;
        end else if (state_d == IDLE) begin
            ena_d = ena_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wm1_q       <= '0;
            target_q    <= '0;
            cur_addr_q  <= '0;
            skip_q      <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sel_rst_n_q <= 1'b0;
            inc_q       <= 1'b0;
            ena_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wm1_q       <= wm1_d;
            target_q    <= target_d;
            cur_addr_q  <= cur_addr_d;
            skip_q      <= skip_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sel_rst_n_q <= sel_rst_n_d;
            inc_q       <= inc_d;
            ena_q       <= ena_d;
        end
    end

    assign req_ready      = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cur_addr       = cur_addr_q;
    assign ctrl_sel_rst_n = sel_rst_n_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_ena       = ena_q;

endmodule

// File: tb/tb_tt_sel_seq.sv
// Directed bench for tt_sel_seq: vector table of whole selections plus reset, busy-hold and abort sequences.
// Build with TT_SEL_SEQ_FAST_EN defined to exercise the fast-path expectations.
module tb_tt_sel_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cfg_pw;
    logic       req_valid;
    logic [9:0] req_addr;
    logic       req_ready, busy, done;
    logic [9:0] cur_addr;
    logic       ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;

    int checks = 0;
    int failures = 0;

    tt_sel_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_pw         (cfg_pw),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .busy           (busy),
        .done           (done),
        .cur_addr       (cur_addr),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pw;
        logic [9:0]  addr;
        int          expDone;
        int          expInc;
        int          expRstLo;
        logic [9:0]  expCur;
        bit          chkMask;
        logic [63:0] expIncMask;
        logic [63:0] expRstMask;
        logic [63:0] expEnaMask;
    } vec_t;

    vec_t vecs[$];

    int          doneCyc, incPulses, rstLoCyc, readyCyc, busyLow;
    logic [9:0]  curAtDone;
    logic        enaAtDone;
    logic [63:0] incMask, rstMask, enaMask;
    logic        expEnaIdle;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One request from IDLE; cycle k is the k-th cycle after the accept edge, sampled at its negedge.
    task automatic applyStimulus(input logic [7:0] pw, input logic [9:0] addr, input int budget,
                                 input bit hold, input logic [9:0] holdAddr);
        logic prevInc;
        @(negedge clk);
        checkOutput("ena_hold_idle", ctrl_ena, expEnaIdle);
        checkOutput("ready_idle", req_ready, 1);
        cfg_pw    = pw;
        req_addr  = addr;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_pw = pw ^ 8'h5A;
        if (hold) req_addr = holdAddr;
        else req_valid = 1'b0;
        doneCyc = -1; incPulses = 0; rstLoCyc = 0; readyCyc = 0; busyLow = 0;
        incMask = '0; rstMask = '0; enaMask = '0;
        curAtDone = '0; enaAtDone = 1'b0;
        prevInc = 1'b0;
        for (int k = 1; k <= budget && doneCyc < 0; k++) begin
            @(negedge clk);
            if (ctrl_sel_inc && !prevInc) incPulses++;
            prevInc = ctrl_sel_inc;
            if (!ctrl_sel_rst_n) rstLoCyc++;
            if (req_ready) readyCyc++;
            if (!busy) busyLow++;
            if (k < 64) begin
                incMask[k] = ctrl_sel_inc;
                rstMask[k] = !ctrl_sel_rst_n;
                enaMask[k] = ctrl_ena;
            end
            if (done) begin
                doneCyc   = k;
                curAtDone = cur_addr;
                enaAtDone = ctrl_ena;
            end
        end
        expEnaIdle = 1'b1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        expEnaIdle = 1'b0;
    endtask

    initial begin
        int secondDone;
        rst_n = 1'b1; cfg_pw = '0; req_valid = 1'b0; req_addr = '0;
        expEnaIdle = 1'b0;
`ifdef TT_SEL_SEQ_FAST_EN
        vecs.push_back('{8'd1, 10'd3, 8, 3, 0, 10'd3, 1'b1, 64'h54, 64'h0, 64'h100});
        vecs.push_back('{8'd1, 10'd3, 2, 0, 0, 10'd3, 1'b1, 64'h0, 64'h0, 64'h4});
        vecs.push_back('{8'd1, 10'd5, 6, 2, 0, 10'd5, 1'b1, 64'h14, 64'h0, 64'h40});
        vecs.push_back('{8'd1, 10'd2, 8, 2, 1, 10'd2, 1'b1, 64'h50, 64'h4, 64'h100});
        vecs.push_back('{8'd2, 10'd2, 3, 0, 0, 10'd2, 1'b1, 64'h0, 64'h0, 64'h8});
        vecs.push_back('{8'd0, 10'd0, 4, 0, 1, 10'd0, 1'b1, 64'h0, 64'h4, 64'h10});
`else
        vecs.push_back('{8'd2, 10'd3, 19, 3, 2, 10'd3, 1'b1, 64'h19980, 64'h18, 64'h80000});
        vecs.push_back('{8'd0, 10'd0, 4, 0, 1, 10'd0, 1'b1, 64'h0, 64'h4, 64'h10});
        vecs.push_back('{8'd1, 10'd2, 8, 2, 1, 10'd2, 1'b1, 64'h50, 64'h4, 64'h100});
        vecs.push_back('{8'd3, 10'd1, 16, 1, 3, 10'd1, 1'b1, 64'h1C00, 64'h70, 64'h10000});
        vecs.push_back('{8'd1, 10'd1023, 2050, 1023, 1, 10'd1023, 1'b0, 64'h0, 64'h0, 64'h0});
        vecs.push_back('{8'd255, 10'd0, 766, 0, 255, 10'd0, 1'b0, 64'h0, 64'h0, 64'h0});
`endif

        // Reset hold and release.
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_sel_rst_n", ctrl_sel_rst_n, 0);
        checkOutput("rst_sel_inc", ctrl_sel_inc, 0);
        checkOutput("rst_ena", ctrl_ena, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_cur_addr", cur_addr, 0);
        #1 rst_n = 1'b1;
        #2 checkOutput("release_pre_edge_sel_rst_n", ctrl_sel_rst_n, 0);
        @(negedge clk);
        checkOutput("release_sel_rst_n", ctrl_sel_rst_n, 1);
        checkOutput("release_ready", req_ready, 1);
        checkOutput("release_ena", ctrl_ena, 0);
        checkOutput("release_cur_addr", cur_addr, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].pw, vecs[i].addr, vecs[i].expDone + 20, 1'b0, 10'd0);
            checkOutput($sformatf("v%0d_done_cycle", i), 64'(doneCyc), 64'(vecs[i].expDone));
            checkOutput($sformatf("v%0d_inc_pulses", i), 64'(incPulses), 64'(vecs[i].expInc));
            checkOutput($sformatf("v%0d_rst_lo_cycles", i), 64'(rstLoCyc), 64'(vecs[i].expRstLo));
            checkOutput($sformatf("v%0d_ready_while_busy", i), 64'(readyCyc), 0);
            checkOutput($sformatf("v%0d_busy_low", i), 64'(busyLow), 0);
            checkOutput($sformatf("v%0d_cur_addr", i), curAtDone, vecs[i].expCur);
            checkOutput($sformatf("v%0d_ena_at_done", i), enaAtDone, 1);
            if (vecs[i].chkMask) begin
                checkOutput($sformatf("v%0d_inc_mask", i), incMask, vecs[i].expIncMask);
                checkOutput($sformatf("v%0d_rst_mask", i), rstMask, vecs[i].expRstMask);
                checkOutput($sformatf("v%0d_ena_mask", i), enaMask, vecs[i].expEnaMask);
            end
        end

        // Request held through a busy sequence is only taken once IDLE returns.
        doReset();
        applyStimulus(8'd1, 10'd4, 60, 1'b1, 10'd5);
`ifdef TT_SEL_SEQ_FAST_EN
        checkOutput("hold_first_done_cycle", 64'(doneCyc), 10);
`else
        checkOutput("hold_first_done_cycle", 64'(doneCyc), 12);
`endif
        checkOutput("hold_first_cur_addr", curAtDone, 4);
        checkOutput("hold_ready_while_busy", 64'(readyCyc), 0);
        @(negedge clk);
        checkOutput("hold_idle_ready", req_ready, 1);
        checkOutput("hold_idle_cur_addr", cur_addr, 4);
        cfg_pw = 8'd1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        secondDone = -1;
        for (int k = 1; k <= 60 && secondDone < 0; k++) begin
            @(negedge clk);
            if (k == 1) checkOutput("hold_second_busy", busy, 1);
            if (done) begin
                secondDone = k;
                checkOutput("hold_second_cur_addr", cur_addr, 5);
            end
        end
`ifdef TT_SEL_SEQ_FAST_EN
        checkOutput("hold_second_done_cycle", 64'(secondDone), 4);
`else
        checkOutput("hold_second_done_cycle", 64'(secondDone), 14);
`endif

        // Reset asserted in cycle 8 of an addr=10 selection aborts everything.
        @(negedge clk);
        cfg_pw = 8'd1; req_addr = 10'd10; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_sel_rst_n", ctrl_sel_rst_n, 0);
        checkOutput("abort_sel_inc", ctrl_sel_inc, 0);
        checkOutput("abort_ena", ctrl_ena, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_ready", req_ready, 0);
        checkOutput("abort_cur_addr", cur_addr, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_release_ready", req_ready, 1);
        checkOutput("abort_release_sel_rst_n", ctrl_sel_rst_n, 1);
        checkOutput("abort_release_cur_addr", cur_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
